spi_slave_cfg: RTL and testbench
================================

# spi_slave_cfg

Parametrised SPI slave for the peripheral subsystem, replacing the fixed 8-bit mode-0 slave. It supports configurable word width, all four SPI modes selected per frame, and MSB- or LSB-first ordering. Multi-word frames are handled with valid/ready handshakes on both the TX and RX sides, and overrun, underrun and aborted-frame conditions are flagged. All logic runs in the system `clk` domain; SPI pins are synchronised and oversampled.

## Interface
- `DATA_W`, 8: bits per word, range 4..32.
- `LSB_FIRST`, 0: 1 = shift LSB first on both MOSI and MISO.
- `TX_FILL`, 0: word shifted out when no TX word is pending (DATA_W bits).

- `clk`  in  1  system clock; `spi_clk` toggle rate ≤ clk/8.
- `rst`  in  1  asynchronous, active-high reset.
- `spi_clk`  in  1  SPI serial clock from master (async).
- `spi_cs_n`  in  1  chip select, active low (async).
- `spi_mosi`  in  1  master-out data (async).
- `spi_miso`  out  1  slave-out data; 0 when not selected.
- `spi_miso_oe`  out  1  MISO output enable; high while selected.
- `cpol`  in  1  clock idle level; latched at frame start.
- `cpha`  in  1  clock phase; latched at frame start.
- `tx_data`  in  DATA_W  next word to transmit.
- `tx_valid`  in  1  tx_data valid.
- `tx_ready`  out  1  TX holding register empty.
- `rx_data`  out  DATA_W  last received word.
- `rx_valid`  out  1  rx_data valid, held until accepted.
- `rx_ready`  in  1  consumer accepts rx_data.
- `rx_overrun`  out  1  one-cycle pulse: completed word dropped.
- `tx_underrun`  out  1  one-cycle pulse: TX_FILL loaded instead of user data.
- `frame_abort`  out  1  one-cycle pulse: CS rose with a partial word.
- `busy`  out  1  high in LOAD/SHIFT.

## Operation
- Synchronisation: `spi_clk`, `spi_cs_n` and `spi_mosi` each pass through 2-FF synchronisers. Synchronised `spi_clk` is registered once more for edge detection. The sampled MOSI value comes from the same synchroniser stage as the detected edge.
- Edge mapping for the latched mode:
  - Sample edge is rising when CPOL==CPHA, falling otherwise.
  - Shift edge is the opposite edge.
  - For CPHA=0, bit 0 of each word is presented at word load. Shift edges advance bits 1..DATA_W-1, and the shift edge after the final sample preloads the next word.
  - For CPHA=1, every shift edge, including the first, presents the next bit.
- State machine:
  - IDLE: synchronised CS high. `busy`=0, `spi_miso`=0, `spi_miso_oe`=0. On synchronised CS falling, latch `cpol`/`cpha` and go to LOAD.
  - LOAD (1 cycle): the TX shift register takes the holding register if it is full, otherwise TX_FILL with a `tx_underrun` pulse. Clear the bit counter. Go to SHIFT.
  - SHIFT: each sample edge shifts MOSI into the RX shifter and increments the bit counter. When the counter reaches DATA_W, the word completes: counter wraps to 0, RX is delivered, and the next TX word is loaded at the next shift edge (CPHA=1 loads on the edge that emits its first bit). On synchronised CS high, return to IDLE.
- CS rising with the bit counter ≠ 0: discard the partial word, pulse `frame_abort`, leave the holding register untouched. CS rising with counter == 0: no pulse.
- TX handshake:
  - `tx_ready` = holding register empty. A transfer occurs when `tx_valid && tx_ready`.
  - The holding register empties in the cycle its word moves to the shifter.
  - Load and user write in the same cycle with the register full: the load takes the old word, the new word is written, and `tx_ready` stays 0.
- RX handshake:
  - On word complete, if `!rx_valid` or `rx_ready` is high that cycle: `rx_data` takes the word and `rx_valid`=1.
  - Otherwise the word is dropped, old `rx_data` is kept, and `rx_overrun` pulses.
  - `rx_valid` clears on `rx_valid && rx_ready` with no new word that cycle.
- Bit order: LSB_FIRST selects shift direction; `rx_data` is always presented with natural bit weights.
- Reset values: `spi_miso`=0, `spi_miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, all pulses 0, `busy`=0, state IDLE, latched mode 0.
- Reset mid-frame: everything returns to reset values immediately; the partial word and the holding register are lost; no `frame_abort` pulse.

## Timing
- Pin-to-internal latency: 2 clk for synchronisation plus 1 clk for edge detection.
- `rx_valid` rises exactly 4 clk rising edges after the first clk edge that captures the final sample edge's new `spi_clk` level.
- LOAD completes ≤4 clk after the CS falling edge. The master must hold ≥6 clk between CS falling and the first `spi_clk` edge; for CPHA=0 that same bound guarantees bit 0 is on MISO.
- MISO updates ≤4 clk after a shift edge. The master must hold ≥8 clk per half-period.
- Between words, `tx_valid` must be accepted before the shift edge that loads the next word to avoid underrun.
- `mode` inputs are ignored while `busy`.

## Test plan
- Mode 0, DATA_W=8, MSB first: master sends 0xAA while `tx_data`=0x5A is pre-loaded -> `rx_data`=0xAA with `rx_valid`=1, master receives 0x5A, no flags.
- All four modes, DATA_W=16, LSB_FIRST=1: master sends 0x1234 with `tx_data`=0xBEEF -> `rx_data`=0x1234 and MISO returns 0xBEEF in every mode.
- 3-word frame, `rx_ready` held 0: master sends 0x11, 0x22, 0x33 -> `rx_data`=0x11 and two `rx_overrun` pulses.
- Same 3-word frame, only the first TX word 0xC3 loaded, TX_FILL=0xFF -> MISO carries 0xC3, 0xFF, 0xFF with two `tx_underrun` pulses.
- CS released after 5 bits -> one `frame_abort` pulse, `rx_valid` stays 0; the next full frame receives correctly.
- Assert `rst` mid-word -> all outputs at reset values on the next clk edge, `tx_ready`=1; a following frame with 0x3C is received correctly.

Source files
------------

// File: rtl/spi_slave_cfg_if.sv
// spi_slave_cfg_if
// Parallel-side bundle of the configurable SPI slave: the TX valid/ready
// holding-register handshake, the RX valid/ready delivery handshake and the
// one-cycle status pulses.
//   slave  modport : used by spi_slave_cfg (drives ready/rx/status)
//   master modport : used by the consuming logic (drives tx/rx_ready)
interface spi_slave_cfg_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              rx_overrun;
    logic              tx_underrun;
    logic              frame_abort;
    logic              busy;

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun,
               frame_abort, busy
    );

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun,
               frame_abort, busy
    );
endinterface

// File: rtl/spi_slave_cfg.sv
// spi_slave_cfg
// SPI slave with configurable word width, per-frame SPI mode (cpol/cpha
// latched when chip select falls) and MSB/LSB-first ordering. SPI pins are
// oversampled in the clk domain. Multi-word frames use a one-word TX holding
// register and a one-word RX output register, both with valid/ready.
// Ports:
//   clk, rst            system clock, async active-high reset
//   spi_clk/cs_n/mosi   asynchronous SPI pins from the master
//   spi_miso, _oe       slave data out and its enable (high while selected)
//   cpol, cpha          SPI mode for the next frame
//   bus                 TX/RX handshakes, overrun/underrun/abort pulses, busy
module spi_slave_cfg #(
    parameter int              DATA_W    = 8,
    parameter bit              LSB_FIRST = 1'b0,
    parameter logic [DATA_W-1:0] TX_FILL = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           spi_clk,
    input  logic           spi_cs_n,
    input  logic           spi_mosi,
    output logic           spi_miso,
    output logic           spi_miso_oe,
    input  logic           cpol,
    input  logic           cpha,
    spi_slave_cfg_if.slave bus
);
    localparam int              CNT_W   = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT
    } state_t;

    state_t            state;
    logic              sclk_s1, sclk_s2, sclk_s3;
    logic              cs_s1, cs_s2;
    logic              mosi_s1, mosi_s2;
    logic              rise_q, fall_q, mosi_q;
    logic              mode_cpol, mode_cpha;
    logic [CNT_W-1:0]  cnt;
    logic              need_load;
    logic [DATA_W-1:0] tx_sh, rx_sh;
    logic [DATA_W-1:0] hold_data;
    logic              hold_full;
    logic              miso_q, oe_q, busy_q;
    logic              underrun_q, abort_q, overrun_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;

    logic              sample_edge, shift_edge;
    logic              word_done, take;
    logic [DATA_W-1:0] next_word, shift_word;

    function automatic logic out_bit(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    // Two-stage synchronisers; the third spi_clk stage only feeds edge
    // detection. Edges are registered together with the MOSI value from the
    // same stage, so the sampled bit lines up with the edge that samples it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            sclk_s1 <= spi_clk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            cs_s1   <= spi_cs_n;
            cs_s2   <= cs_s1;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
            rise_q  <= sclk_s2 & ~sclk_s3;
            fall_q  <= ~sclk_s2 & sclk_s3;
            mosi_q  <= mosi_s2;
        end
    end

    assign sample_edge = (mode_cpol == mode_cpha) ? rise_q : fall_q;
    assign shift_edge  = (mode_cpol == mode_cpha) ? fall_q : rise_q;
    assign word_done   = (state == ST_SHIFT) && (cnt == CNT_MAX);
    assign next_word   = hold_full ? hold_data : TX_FILL;
    // A word moves from the holding register either in LOAD or on the first
    // shift edge after a completed word.
    assign take        = (state == ST_LOAD) ||
                         ((state == ST_SHIFT) && !cs_s2 && shift_edge && need_load);
    assign shift_word  = need_load ? next_word : tx_sh;

    // TX holding register. A load and a write in the same cycle are both
    // honoured: the load takes the old word, the new word replaces it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (bus.tx_valid && (!hold_full || take)) begin
            hold_full <= 1'b1;
            hold_data <= bus.tx_data;
        end else if (take) begin
            hold_full <= 1'b0;
        end
    end

    // state    | meaning
    // ST_IDLE  | deselected; waiting for chip select to fall
    // ST_LOAD  | one cycle: first TX word into the shifter, counter cleared
    // ST_SHIFT | sampling/shifting on SPI edges until chip select rises
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode_cpol  <= 1'b0;
            mode_cpha  <= 1'b0;
            cnt        <= '0;
            need_load  <= 1'b0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    miso_q    <= 1'b0;
                    cnt       <= '0;
                    need_load <= 1'b0;
                    if (!cs_s2) begin
                        mode_cpol <= cpol;
                        mode_cpha <= cpha;
                        oe_q      <= 1'b1;
                        busy_q    <= 1'b1;
                        state     <= ST_LOAD;
                    end else begin
                        oe_q   <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    cnt        <= '0;
                    need_load  <= 1'b0;
                    underrun_q <= !hold_full;
                    // CPHA=0 presents bit 0 now; CPHA=1 waits for the first
                    // shift edge to present it.
                    if (!mode_cpha) begin
                        miso_q <= out_bit(next_word);
                        tx_sh  <= advance(next_word);
                    end else begin
                        tx_sh  <= next_word;
                    end
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cs_s2) begin
                        // A word completed but not yet delivered is not partial.
                        abort_q   <= (cnt != '0) && (cnt != CNT_MAX);
                        cnt       <= '0;
                        need_load <= 1'b0;
                        miso_q    <= 1'b0;
                        oe_q      <= 1'b0;
                        busy_q    <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        if (cnt == CNT_MAX) begin
                            cnt       <= '0;
                            need_load <= 1'b1;
                        end else if (sample_edge) begin
                            rx_sh <= LSB_FIRST ? {mosi_q, rx_sh[DATA_W-1:1]}
                                               : {rx_sh[DATA_W-2:0], mosi_q};
                            cnt   <= cnt + CNT_W'(1);
                        end
                        if (shift_edge) begin
                            if (need_load) begin
                                underrun_q <= !hold_full;
                                need_load  <= 1'b0;
                            end
                            miso_q <= out_bit(shift_word);
                            tx_sh  <= advance(shift_word);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // RX output register: a completed word is dropped only if the previous
    // one is still pending and not being accepted this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (word_done) begin
                if (!rx_valid_q || bus.rx_ready) begin
                    rx_data_q  <= rx_sh;
                    rx_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && bus.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign spi_miso        = miso_q;
    assign spi_miso_oe     = oe_q;
    assign bus.tx_ready    = ~hold_full;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_overrun  = overrun_q;
    assign bus.tx_underrun = underrun_q;
    assign bus.frame_abort = abort_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_spi_slave_cfg.sv
module tb_spi_slave_cfg;
    localparam int HALF = 100;   // SPI half period: 10 clk

    logic clk, rst;
    logic spi_clk, spi_mosi, cs8_n, cs16_n, cpol, cpha;
    logic miso8, oe8, miso16, oe16;

    spi_slave_cfg_if #(.DATA_W(8))  b8 ();
    spi_slave_cfg_if #(.DATA_W(16)) b16 ();

    spi_slave_cfg #(.DATA_W(8), .LSB_FIRST(1'b0), .TX_FILL(8'hFF)) dut8 (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(cs8_n),
        .spi_mosi(spi_mosi), .spi_miso(miso8), .spi_miso_oe(oe8),
        .cpol(cpol), .cpha(cpha), .bus(b8)
    );

    spi_slave_cfg #(.DATA_W(16), .LSB_FIRST(1'b1), .TX_FILL(16'h0000)) dut16 (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(cs16_n),
        .spi_mosi(spi_mosi), .spi_miso(miso16), .spi_miso_oe(oe16),
        .cpol(cpol), .cpha(cpha), .bus(b16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] q_rx8[$];
    logic [31:0] q_rx16[$];
    logic [31:0] q_miso[$];
    logic [31:0] mosi_w[4];
    int ovr8 = 0, udr8 = 0, abt8 = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard side: RX words are popped and compared as they are accepted.
    always @(negedge clk) begin
        if (b8.rx_overrun)  ovr8++;
        if (b8.tx_underrun) udr8++;
        if (b8.frame_abort) abt8++;
        if (b8.rx_valid && b8.rx_ready) begin
            if (q_rx8.size() == 0) chk("rx8_unexpected", 32'(q_rx8.size()), 1);
            else                   chk("rx8_data", 32'(b8.rx_data), q_rx8.pop_front());
        end
        if (b16.rx_valid && b16.rx_ready) begin
            if (q_rx16.size() == 0) chk("rx16_unexpected", 32'(q_rx16.size()), 1);
            else                    chk("rx16_data", 32'(b16.rx_data), q_rx16.pop_front());
        end
    end

    task automatic push_tx(input bit sel, input logic [31:0] w);
        int t;
        t = 0;
        @(posedge clk); #1;
        while ((sel ? b16.tx_ready : b8.tx_ready) !== 1'b1 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) chk("tx_ready_timeout", 32'(sel ? b16.tx_ready : b8.tx_ready), 1);
        if (sel) begin b16.tx_data = w[15:0]; b16.tx_valid = 1'b1; end
        else     begin b8.tx_data  = w[7:0];  b8.tx_valid  = 1'b1; end
        @(posedge clk); #1;
        b16.tx_valid = 1'b0;
        b8.tx_valid  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q_rx8.size() != 0 || q_rx16.size() != 0) && t < 300) begin
            @(posedge clk);
            t++;
        end
        chk("rx_drain", 32'(q_rx8.size() + q_rx16.size()), 0);
    endtask

    // SPI master: shifts mosi_w[] out, reassembles MISO words and compares
    // them with the expected-MISO queue.
    task automatic spi_frame(input bit sel, input bit m_cpol, input bit m_cpha,
                             input bit lsb, input int w, input int nbits,
                             input bit refill, input logic [31:0] refill_word,
                             input bit chk_miso, input bit keep_cs);
        logic [31:0] rx_word;
        logic        mb;
        int          wi, bi, pos;
        cpol    = m_cpol;
        cpha    = m_cpha;
        spi_clk = m_cpol;
        #(HALF);
        if (sel) cs16_n = 1'b0; else cs8_n = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("busy", 32'(sel ? b16.busy : b8.busy), 1);
        chk("miso_oe", 32'(sel ? oe16 : oe8), 1);
        if (refill) push_tx(sel, refill_word);
        #(HALF);
        rx_word = '0;
        for (int b = 0; b < nbits; b++) begin
            wi  = b / w;
            bi  = b % w;
            pos = lsb ? bi : (w - 1 - bi);
            if (!m_cpha) begin
                spi_mosi = mosi_w[wi][pos];
                #(HALF);
                spi_clk = ~spi_clk;
                mb = sel ? miso16 : miso8;
                #(HALF);
                spi_clk = ~spi_clk;
            end else begin
                spi_clk = ~spi_clk;
                spi_mosi = mosi_w[wi][pos];
                #(HALF);
                spi_clk = ~spi_clk;
                mb = sel ? miso16 : miso8;
                #(HALF);
            end
            rx_word[pos] = mb;
            if (bi == w - 1) begin
                if (chk_miso) begin
                    if (q_miso.size() == 0) chk("miso_unexpected", 32'(q_miso.size()), 1);
                    else                    chk("miso_word", rx_word, q_miso.pop_front());
                end
                rx_word = '0;
            end
        end
        if (!keep_cs) begin
            #(HALF);
            cs8_n  = 1'b1;
            cs16_n = 1'b1;
            #(2 * HALF);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int o0, u0, a0;
        rst = 1'b1;
        spi_clk = 1'b0; spi_mosi = 1'b0; cs8_n = 1'b1; cs16_n = 1'b1;
        cpol = 1'b0; cpha = 1'b0;
        b8.tx_data = '0;  b8.tx_valid = 1'b0;  b8.rx_ready = 1'b1;
        b16.tx_data = '0; b16.tx_valid = 1'b0; b16.rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_ready", 32'(b8.tx_ready), 1);
        chk("rst_rx_valid", 32'(b8.rx_valid), 0);
        chk("rst_rx_data", 32'(b8.rx_data), 0);
        chk("rst_busy", 32'(b8.busy), 0);
        chk("rst_miso_oe", 32'(oe8), 0);
        chk("rst_miso", 32'(miso8), 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // Mode 0, 8-bit MSB first
        o0 = ovr8; u0 = udr8; a0 = abt8;
        push_tx(0, 32'h5A);
        mosi_w[0] = 32'hAA;
        q_rx8.push_back(32'hAA);
        q_miso.push_back(32'h5A);
        spi_frame(0, 0, 0, 0, 8, 8, 1, 32'h00, 1, 0);
        drain();
        chk("t1_overrun", 32'(ovr8 - o0), 0);
        chk("t1_underrun", 32'(udr8 - u0), 0);
        chk("t1_abort", 32'(abt8 - a0), 0);

        // All four modes, 16-bit LSB first
        for (int m = 0; m < 4; m++) begin
            push_tx(1, 32'hBEEF);
            mosi_w[0] = 32'h1234;
            q_rx16.push_back(32'h1234);
            q_miso.push_back(32'hBEEF);
            spi_frame(1, m[1], m[0], 1, 16, 16, 0, 32'h0, 1, 0);
            drain();
        end

        // Three words with rx_ready low: two overruns, first word kept
        o0 = ovr8;
        b8.rx_ready = 1'b0;
        mosi_w[0] = 32'h11; mosi_w[1] = 32'h22; mosi_w[2] = 32'h33;
        q_rx8.push_back(32'h11);
        spi_frame(0, 0, 0, 0, 8, 24, 0, 32'h0, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("t3_overrun", 32'(ovr8 - o0), 2);
        chk("t3_rx_held", 32'(b8.rx_data), 32'h11);
        b8.rx_ready = 1'b1;
        drain();

        // Three words, one TX word supplied (mode 1): fill words follow
        o0 = ovr8; u0 = udr8;
        push_tx(0, 32'hC3);
        mosi_w[0] = 32'h01; mosi_w[1] = 32'h02; mosi_w[2] = 32'h03;
        q_rx8.push_back(32'h01); q_rx8.push_back(32'h02); q_rx8.push_back(32'h03);
        q_miso.push_back(32'hC3); q_miso.push_back(32'hFF); q_miso.push_back(32'hFF);
        spi_frame(0, 0, 1, 0, 8, 24, 0, 32'h0, 1, 0);
        drain();
        chk("t4_underrun", 32'(udr8 - u0), 2);
        chk("t4_overrun", 32'(ovr8 - o0), 0);

        // Abort after 5 bits, then a clean frame
        a0 = abt8;
        mosi_w[0] = 32'hF0;
        spi_frame(0, 0, 0, 0, 8, 5, 0, 32'h0, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("t5_abort", 32'(abt8 - a0), 1);
        chk("t5_rx_valid", 32'(b8.rx_valid), 0);
        push_tx(0, 32'h69);
        mosi_w[0] = 32'h96;
        q_rx8.push_back(32'h96);
        q_miso.push_back(32'h69);
        spi_frame(0, 0, 0, 0, 8, 8, 1, 32'h00, 1, 0);
        drain();
        chk("t5_abort_after", 32'(abt8 - a0), 1);

        // Reset in the middle of a word with the holding register full
        mosi_w[0] = 32'hFF;
        spi_frame(0, 0, 0, 0, 8, 3, 0, 32'h0, 0, 1);
        push_tx(0, 32'h77);
        chk("t6_tx_full", 32'(b8.tx_ready), 0);
        a0 = abt8;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_tx_ready", 32'(b8.tx_ready), 1);
        chk("t6_rx_valid", 32'(b8.rx_valid), 0);
        chk("t6_rx_data", 32'(b8.rx_data), 0);
        chk("t6_busy", 32'(b8.busy), 0);
        chk("t6_miso_oe", 32'(oe8), 0);
        chk("t6_miso", 32'(miso8), 0);
        cs8_n = 1'b1;
        spi_clk = 1'b0;
        repeat (3) @(posedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_no_abort", 32'(abt8 - a0), 0);
        push_tx(0, 32'hA5);
        mosi_w[0] = 32'h3C;
        q_rx8.push_back(32'h3C);
        q_miso.push_back(32'hA5);
        spi_frame(0, 0, 0, 0, 8, 8, 1, 32'h00, 1, 0);
        drain();

        chk("miso_queue_left", 32'(q_miso.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
